// File: rtl/arbitro_memoria_dados_if.sv
// Bus bundle for the data-memory arbiter: CPU port, external loader port, memory command port.
// The owner field exposes the previous-cycle owner for debug/coverage.
interface arbitro_memoria_dados_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              cpu_rd;
    logic              cpu_wr;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_stall;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;

    logic              ext_req;
    logic              ext_we;
    logic [ADDR_W-1:0] ext_addr;
    logic [DATA_W-1:0] ext_wdata;
    logic              ext_gnt;
    logic              ext_rvalid;
    logic [DATA_W-1:0] ext_rdata;

    logic              mem_rd;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic [1:0]        owner;

    modport slave (
        input  cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
        input  ext_req, ext_we, ext_addr, ext_wdata,
        input  mem_rdata,
        output cpu_stall, cpu_rvalid, cpu_rdata,
        output ext_gnt, ext_rvalid, ext_rdata,
        output mem_rd, mem_wr, mem_addr, mem_wdata,
        output owner
    );

    modport master (
        output cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
        output ext_req, ext_we, ext_addr, ext_wdata,
        output mem_rdata,
        input  cpu_stall, cpu_rvalid, cpu_rdata,
        input  ext_gnt, ext_rvalid, ext_rdata,
        input  mem_rd, mem_wr, mem_addr, mem_wdata,
        input  owner
    );
endinterface

// File: rtl/arbitro_memoria_dados.sv
// Single-cycle arbiter between the CPU and an external port for a sync single-port data memory.
// Optional macro DMEM_ARB_ROUND_ROBIN_EN: alternate grants on contention instead of CPU priority.
module arbitro_memoria_dados #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 8,
    parameter int MAX_WAIT = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    arbitro_memoria_dados_if.slave bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_CPU, ST_EXT, ST_FORCED} owner_t;

    localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

    owner_t            state_q, state_d;
    logic [3:0]        wait_cnt_q, wait_cnt_d;
    logic              cpu_pend_q, cpu_pend_d;
    logic              ext_pend_q, ext_pend_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] ext_rdata_q, ext_rdata_d;
    logic              cpu_req, forced, cpu_gnt, ext_gnt;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
    logic              last_owner_q, last_owner_d;   // 0 = CPU, 1 = ext
`endif

    always_comb begin
        cpu_req = bus.cpu_rd | bus.cpu_wr;
        forced  = ~reset & bus.ext_req & (wait_cnt_q == MAX_W);
`ifdef DMEM_ARB_ROUND_ROBIN_EN
        if (forced) begin
            cpu_gnt = 1'b0;
        end else if (cpu_req & bus.ext_req) begin
            cpu_gnt = ~reset & last_owner_q;
        end else begin
            cpu_gnt = ~reset & cpu_req;
        end
`else
        cpu_gnt = ~reset & ~forced & cpu_req;
`endif
        ext_gnt = ~reset & ~cpu_gnt & bus.ext_req;

        bus.mem_rd    = 1'b0;
        bus.mem_wr    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        if (cpu_gnt) begin
            // write wins when both strobes are raised
            bus.mem_rd    = bus.cpu_rd & ~bus.cpu_wr;
            bus.mem_wr    = bus.cpu_wr;
            bus.mem_addr  = bus.cpu_addr;
            bus.mem_wdata = bus.cpu_wdata;
        end else if (ext_gnt) begin
            bus.mem_rd    = ~bus.ext_we;
            bus.mem_wr    = bus.ext_we;
            bus.mem_addr  = bus.ext_addr;
            bus.mem_wdata = bus.ext_wdata;
        end

        bus.ext_gnt   = ext_gnt;
        bus.cpu_stall = ~reset & cpu_req & ~cpu_gnt;

        cpu_pend_d  = cpu_gnt & bus.cpu_rd & ~bus.cpu_wr;
        ext_pend_d  = ext_gnt & ~bus.ext_we;
        cpu_rdata_d = cpu_pend_q ? bus.mem_rdata : cpu_rdata_q;
        ext_rdata_d = ext_pend_q ? bus.mem_rdata : ext_rdata_q;

        bus.cpu_rvalid = cpu_pend_q;
        bus.ext_rvalid = ext_pend_q;
        bus.cpu_rdata  = cpu_rdata_d;
        bus.ext_rdata  = ext_rdata_d;

        if (~bus.ext_req | ext_gnt) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q != MAX_W) begin
            wait_cnt_d = wait_cnt_q + 4'd1;
        end else begin
            wait_cnt_d = wait_cnt_q;
        end

        if (forced)       state_d = ST_FORCED;
        else if (cpu_gnt) state_d = ST_CPU;
        else if (ext_gnt) state_d = ST_EXT;
        else              state_d = ST_IDLE;
        bus.owner = state_q;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
        if (cpu_gnt)      last_owner_d = 1'b0;
        else if (ext_gnt) last_owner_d = 1'b1;
        else              last_owner_d = last_owner_q;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            wait_cnt_q  <= '0;
            cpu_pend_q  <= 1'b0;
            ext_pend_q  <= 1'b0;
            cpu_rdata_q <= '0;
            ext_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            cpu_pend_q  <= cpu_pend_d;
            ext_pend_q  <= ext_pend_d;
            cpu_rdata_q <= cpu_rdata_d;
            ext_rdata_q <= ext_rdata_d;
        end
    end

`ifdef DMEM_ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) last_owner_q <= 1'b0;
        else       last_owner_q <= last_owner_d;
    end
`endif
endmodule

// File: tb/tb_arbitro_memoria_dados.sv
// Directed bench for arbitro_memoria_dados with a behavioural 256x8 sync memory.
module tb_arbitro_memoria_dados;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   tests = 0;
    int   fails = 0;
    logic [7:0] mem [256];

    arbitro_memoria_dados_if #(.ADDR_W(8), .DATA_W(8)) bus ();
    arbitro_memoria_dados #(.ADDR_W(8), .DATA_W(8), .MAX_WAIT(4)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.mem_wr) mem[bus.mem_addr] <= bus.mem_wdata;
        if (bus.mem_rd) bus.mem_rdata <= mem[bus.mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.cpu_rd = 0; bus.cpu_wr = 0; bus.cpu_addr = 0; bus.cpu_wdata = 0;
        bus.ext_req = 0; bus.ext_we = 0; bus.ext_addr = 0; bus.ext_wdata = 0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h20] = 8'h5A;
        bus.mem_rdata = 8'h00;
        idle_inputs();

        // reset state
        @(negedge clk); #1;
        chk("rst_stall", bus.cpu_stall, 0);
        chk("rst_cpu_rvalid", bus.cpu_rvalid, 0);
        chk("rst_ext_gnt", bus.ext_gnt, 0);
        chk("rst_mem_rd", bus.mem_rd, 0);
        chk("rst_wait", dut.wait_cnt_q, 0);
        reset = 0;

        // reset mid-read: read granted, reset arrives before the capturing edge
        @(negedge clk); bus.cpu_rd = 1; bus.cpu_addr = 8'h10; #1;
        chk("mid_gnt_rd", bus.mem_rd, 1);
        chk("mid_gnt_addr", bus.mem_addr, 8'h10);
        #3 reset = 1; #1;
        chk("mid_rst_mem_rd", bus.mem_rd, 0);
        chk("mid_rst_stall", bus.cpu_stall, 0);
        chk("mid_rst_addr", bus.mem_addr, 0);
        @(negedge clk); reset = 0; idle_inputs(); #1;
        chk("mid_rst_rvalid", bus.cpu_rvalid, 0);
        chk("mid_rst_wait", dut.wait_cnt_q, 0);
        @(negedge clk); #1;
        chk("mid_rst_rvalid2", bus.cpu_rvalid, 0);

        // CPU read of 0x20
        @(negedge clk); bus.cpu_rd = 1; bus.cpu_addr = 8'h20; #1;
        chk("rd_mem_rd", bus.mem_rd, 1);
        chk("rd_mem_addr", bus.mem_addr, 8'h20);
        chk("rd_stall", bus.cpu_stall, 0);
        @(negedge clk); idle_inputs(); #1;
        chk("rd_rvalid", bus.cpu_rvalid, 1);
        chk("rd_rdata", bus.cpu_rdata, 8'h5A);
        chk("rd_ext_rvalid", bus.ext_rvalid, 0);
        chk("idle_mem_addr", bus.mem_addr, 0);
        chk("idle_mem_rd", bus.mem_rd, 0);
        @(negedge clk); #1;
        chk("rd_rvalid_once", bus.cpu_rvalid, 0);
        chk("rd_rdata_hold", bus.cpu_rdata, 8'h5A);

        // external write 0x33 -> 0x40
        @(negedge clk); bus.ext_req = 1; bus.ext_we = 1; bus.ext_addr = 8'h40; bus.ext_wdata = 8'h33; #1;
        chk("extw_gnt", bus.ext_gnt, 1);
        chk("extw_mem_wr", bus.mem_wr, 1);
        chk("extw_mem_rd", bus.mem_rd, 0);
        chk("extw_addr", bus.mem_addr, 8'h40);
        chk("extw_wdata", bus.mem_wdata, 8'h33);
        @(negedge clk); idle_inputs(); #1;
        chk("extw_no_rvalid", bus.ext_rvalid, 0);
        chk("extw_mem", mem[8'h40], 8'h33);

        // read and write together: write wins, no read return
        @(negedge clk); bus.cpu_rd = 1; bus.cpu_wr = 1; bus.cpu_addr = 8'h08; bus.cpu_wdata = 8'h11; #1;
        chk("rw_mem_wr", bus.mem_wr, 1);
        chk("rw_mem_rd", bus.mem_rd, 0);
        chk("rw_addr", bus.mem_addr, 8'h08);
        chk("rw_wdata", bus.mem_wdata, 8'h11);
        @(negedge clk); idle_inputs(); #1;
        chk("rw_no_rvalid", bus.cpu_rvalid, 0);
        chk("rw_mem", mem[8'h08], 8'h11);

`ifdef DMEM_ARB_ROUND_ROBIN_EN
        // fresh reset so last_owner is CPU, then both read continuously
        @(negedge clk); reset = 1;
        @(negedge clk); reset = 0;
        bus.cpu_rd = 1; bus.cpu_addr = 8'h20;
        bus.ext_req = 1; bus.ext_we = 0; bus.ext_addr = 8'h08;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk("rr_ext_gnt", bus.ext_gnt, (c % 2 == 0) ? 1 : 0);
            chk("rr_stall", bus.cpu_stall, (c % 2 == 0) ? 1 : 0);
            chk("rr_addr", bus.mem_addr, (c % 2 == 0) ? 8'h08 : 8'h20);
            chk("rr_ext_rvalid", bus.ext_rvalid, (c % 2 == 1) ? 1 : 0);
            chk("rr_cpu_rvalid", bus.cpu_rvalid, (c >= 2 && c % 2 == 0) ? 1 : 0);
            if (c % 2 == 1) chk("rr_ext_rdata", bus.ext_rdata, 8'h11);
            if (c >= 2 && c % 2 == 0) chk("rr_cpu_rdata", bus.cpu_rdata, 8'h5A);
            chk("rr_wait_le1", (dut.wait_cnt_q <= 1) ? 1 : 0, 1);
            @(negedge clk);
        end
        idle_inputs();
`else
        // CPU reads every cycle while ext waits: forced grant on the 5th cycle
        @(negedge clk);
        bus.cpu_rd = 1; bus.cpu_addr = 8'h20;
        bus.ext_req = 1; bus.ext_we = 0; bus.ext_addr = 8'h08;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk("starve_ext_gnt", bus.ext_gnt, 0);
            chk("starve_stall", bus.cpu_stall, 0);
            chk("starve_addr", bus.mem_addr, 8'h20);
            chk("starve_wait", dut.wait_cnt_q, c);
            @(negedge clk);
        end
        #1;
        chk("forced_gnt", bus.ext_gnt, 1);
        chk("forced_stall", bus.cpu_stall, 1);
        chk("forced_addr", bus.mem_addr, 8'h08);
        @(negedge clk); bus.ext_req = 0; #1;
        chk("after_cpu_served", bus.mem_addr, 8'h20);
        chk("after_stall", bus.cpu_stall, 0);
        chk("after_ext_rvalid", bus.ext_rvalid, 1);
        chk("after_ext_rdata", bus.ext_rdata, 8'h11);
        chk("after_cpu_rvalid", bus.cpu_rvalid, 0);
        chk("after_owner", bus.owner, 3);
        chk("after_wait", dut.wait_cnt_q, 0);
        @(negedge clk); idle_inputs(); #1;
        chk("after_cpu_rvalid2", bus.cpu_rvalid, 1);
        chk("after_owner2", bus.owner, 1);

        // simultaneous writes: CPU wins, ext held until next cycle
        @(negedge clk);
        bus.cpu_wr = 1; bus.cpu_addr = 8'h50; bus.cpu_wdata = 8'hAA;
        bus.ext_req = 1; bus.ext_we = 1; bus.ext_addr = 8'h51; bus.ext_wdata = 8'hBB; #1;
        chk("ww_gnt", bus.ext_gnt, 0);
        chk("ww_addr", bus.mem_addr, 8'h50);
        chk("ww_wdata", bus.mem_wdata, 8'hAA);
        @(negedge clk); bus.cpu_wr = 0; #1;
        chk("ww_ext_gnt", bus.ext_gnt, 1);
        chk("ww_ext_addr", bus.mem_addr, 8'h51);
        @(negedge clk); idle_inputs(); #1;
        chk("ww_mem50", mem[8'h50], 8'hAA);
        chk("ww_mem51", mem[8'h51], 8'hBB);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
